// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - shared types for the divider arbiter slice
package friscv_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Operand fields are sized for the widest XLEN; narrower builds zero-extend.
  typedef struct packed {
    logic                sgn;
    logic [XLEN_MAX-1:0] divd;
    logic [XLEN_MAX-1:0] divs;
  } div_op_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/friscv_rr_arbiter.sv
// rtl/friscv_rr_arbiter.sv - combinational round-robin picker, pointer kept by the parent
module friscv_rr_arbiter
  import friscv_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  int k;

  // First requester at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/friscv_div_arbiter.sv
// rtl/friscv_div_arbiter.sv - shares one iterative divider among NB_REQ requesters
module friscv_div_arbiter
  import friscv_pkg::*;
#(
  parameter  int NB_REQ = 2,
  parameter  int XLEN   = 32,
  localparam int IDW    = idx_width(NB_REQ)
) (
  input  logic                   aclk,
  input  logic                   srst,
  input  logic [NB_REQ-1:0]      req_valid,
  output logic [NB_REQ-1:0]      req_ready,
  input  logic [NB_REQ-1:0]      req_signed,
  input  logic [NB_REQ*XLEN-1:0] req_divd,
  input  logic [NB_REQ*XLEN-1:0] req_divs,
  output logic [NB_REQ-1:0]      rsp_valid,
  input  logic [NB_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]        rsp_quot,
  output logic [XLEN-1:0]        rsp_rem,
  output logic                   rsp_zdiv,
  output logic                   div_valid,
  input  logic                   div_ready,
  output logic                   div_signed,
  output logic [XLEN-1:0]        div_divd,
  output logic [XLEN-1:0]        div_divs,
  input  logic                   div_o_valid,
  output logic                   div_o_ready,
  input  logic [XLEN-1:0]        div_quot,
  input  logic [XLEN-1:0]        div_rem,
  input  logic                   div_zdiv,
  output logic                   busy,
  output logic [IDW-1:0]         owner
);

  arb_state_t      state_q, state_d;
  div_op_t         op_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic            zdiv_q;

  logic [NB_REQ-1:0] grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_found;
  logic              unused_op;

  friscv_rr_arbiter #(
    .N  (NB_REQ),
    .IW (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    rsp_valid   = '0;
    div_valid   = 1'b0;
    div_o_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready = grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        div_valid = 1'b1;
        if (div_ready) state_d = WAIT;
      end
      WAIT: begin
        div_o_ready = 1'b1;
        if (div_o_valid) state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      zdiv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_found) begin
        owner_q   <= grant_idx;
        op_q.sgn  <= req_signed[grant_idx];
        op_q.divd <= XLEN_MAX'(req_divd[grant_idx*XLEN +: XLEN]);
        op_q.divs <= XLEN_MAX'(req_divs[grant_idx*XLEN +: XLEN]);
      end
      if (state_q == WAIT && div_o_valid) begin
        quot_q <= div_quot;
        rem_q  <= div_rem;
        zdiv_q <= div_zdiv;
      end
      // The pointer only moves once the owner has taken its result.
      if (state_q == RESP && rsp_ready[owner_q]) begin
        rr_ptr_q <= (owner_q == IDW'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  assign div_signed = op_q.sgn;
  assign div_divd   = op_q.divd[XLEN-1:0];
  assign div_divs   = op_q.divs[XLEN-1:0];
  assign rsp_quot   = quot_q;
  assign rsp_rem    = rem_q;
  assign rsp_zdiv   = zdiv_q;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;

  // Upper operand bits are constant zero when XLEN < XLEN_MAX.
  assign unused_op = &{1'b0, op_q};

endmodule

// File: tb/tb_friscv_div_arbiter.sv
// tb/tb_friscv_div_arbiter.sv - self-checking bench with a behavioural divider and arbitration model
module tb_friscv_div_arbiter;

  localparam int NB = 3;
  localparam int XL = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              srst;
  logic [NB-1:0]     req_valid, req_ready, req_signed;
  logic [NB*XL-1:0]  req_divd, req_divs;
  logic [NB-1:0]     rsp_valid, rsp_ready;
  logic [XL-1:0]     rsp_quot, rsp_rem;
  logic              rsp_zdiv;
  logic              div_valid, div_ready, div_signed;
  logic [XL-1:0]     div_divd, div_divs;
  logic              div_o_valid, div_o_ready;
  logic [XL-1:0]     div_quot, div_rem;
  logic              div_zdiv;
  logic              busy;
  logic [IW-1:0]     owner;

  always #5 clk = ~clk;

  friscv_div_arbiter #(.NB_REQ(NB), .XLEN(XL)) dut (
    .aclk(clk), .srst(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_divd(req_divd), .req_divs(req_divs),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_zdiv(rsp_zdiv),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
    .div_divd(div_divd), .div_divs(div_divs),
    .div_o_valid(div_o_valid), .div_o_ready(div_o_ready),
    .div_quot(div_quot), .div_rem(div_rem), .div_zdiv(div_zdiv),
    .busy(busy), .owner(owner)
  );

  typedef struct packed {
    logic [XL-1:0] q;
    logic [XL-1:0] r;
    logic          z;
  } res_t;

  typedef struct {
    int            idx;
    logic          s;
    logic [XL-1:0] a, b, q, r;
    logic          z;
  } vec_t;

  int vecs = 0;
  int errs = 0;
  int mptr = 0;

  // RISC-V M-extension division semantics.
  function automatic res_t ref_div(input logic s, input logic [XL-1:0] a, input logic [XL-1:0] b);
    res_t o;
    o.z = (b == 0);
    if (b == 0) begin
      o.q = '1;
      o.r = a;
    end else if (!s) begin
      o.q = a / b;
      o.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      o.q = a;
      o.r = '0;
    end else begin
      o.q = $signed(a) / $signed(b);
      o.r = $signed(a) % $signed(b);
    end
    return o;
  endfunction

  function automatic int predict(input logic [NB-1:0] v, input int p);
    for (int o = 0; o < NB; o++) if (v[(p + o) % NB]) return (p + o) % NB;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Behavioural divider: random input stalls, 1..4 cycle latency, holds result until taken.
  logic          acc, ret, d_s;
  logic [XL-1:0] d_a, d_b;
  int            cnt;
  bit            dbusy;
  res_t          dres;

  initial begin
    div_ready = 0; div_o_valid = 0; div_quot = 0; div_rem = 0; div_zdiv = 0;
    dbusy = 0; cnt = 0;
    forever begin
      @(negedge clk);
      acc = div_valid && div_ready;
      ret = div_o_valid && div_o_ready;
      d_s = div_signed; d_a = div_divd; d_b = div_divs;
      @(posedge clk);
      #1;
      if (srst) begin
        dbusy = 0; div_o_valid = 0; div_ready = 0;
      end else begin
        if (ret) begin
          div_o_valid = 0;
          dbusy = 0;
        end
        if (acc) begin
          dbusy = 1;
          cnt = $urandom_range(1, 4);
          dres = ref_div(d_s, d_a, d_b);
        end else if (dbusy && !div_o_valid) begin
          cnt--;
          if (cnt == 0) begin
            div_o_valid = 1;
            div_quot = dres.q; div_rem = dres.r; div_zdiv = dres.z;
          end
        end
        div_ready = !dbusy && ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic set_req(input int i, input logic s, input logic [XL-1:0] a, input logic [XL-1:0] b);
    req_signed[i] = s;
    req_divd[i*XL +: XL] = a;
    req_divs[i*XL +: XL] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    srst = 1; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    srst = 0;
    mptr = 0;
  endtask

  // One full transaction for requester e, which must be the one granted.
  task automatic run_op(input int e, input bit drop, input int stall, output res_t got, output int waited);
    int   n;
    res_t exp;
    logic hs_prev;
    #1;
    n = 0;
    while (req_ready == 0 && n < 100) begin tick(); n++; end
    waited = n;
    chk("grant_onehot", 64'(req_ready), 64'd1 << e);
    exp = ref_div(req_signed[e], req_divd[e*XL +: XL], req_divs[e*XL +: XL]);
    tick();
    chk("div_valid_lat", 64'(div_valid), 64'd1);
    chk("div_divd", 64'(div_divd), 64'(req_divd[e*XL +: XL]));
    chk("div_divs", 64'(div_divs), 64'(req_divs[e*XL +: XL]));
    chk("owner", 64'(owner), 64'(e));
    if (drop) req_valid[e] = 1'b0;
    n = 0;
    hs_prev = 0;
    while (rsp_valid == 0 && n < 100) begin
      hs_prev = div_o_valid && div_o_ready;
      tick();
      n++;
    end
    chk("rsp_lat", 64'(hs_prev), 64'd1);
    chk("rsp_route", 64'(rsp_valid), 64'd1 << e);
    chk("rsp_quot", 64'(rsp_quot), 64'(exp.q));
    chk("rsp_rem", 64'(rsp_rem), 64'(exp.r));
    chk("rsp_zdiv", 64'(rsp_zdiv), 64'(exp.z));
    got = '{q: rsp_quot, r: rsp_rem, z: rsp_zdiv};
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1 << e);
      chk("hold_quot", 64'(rsp_quot), 64'(exp.q));
      chk("hold_rem", 64'(rsp_rem), 64'(exp.r));
      chk("hold_no_grant", 64'(req_ready), 64'd0);
      chk("hold_div_idle", 64'(div_valid), 64'd0);
    end
    rsp_ready[e] = 1'b1;
    tick();
    rsp_ready[e] = 1'b0;
    mptr = (e + 1) % NB;
    chk("idle_after_rsp", 64'(busy), 64'd0);
  endtask

  vec_t tbl[7];
  res_t got;
  int   w, e, n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{1, 1'b1, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFE,  1'b0};
    tbl[2] = '{0, 1'b0, 32'h55,         32'd0,          32'hFFFF_FFFF,  32'h55,         1'b1};
    tbl[3] = '{2, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[4] = '{1, 1'b0, 32'hFFFF_FFEC,  32'd3,          32'h5555_554E,  32'd2,          1'b0};
    tbl[5] = '{2, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[6] = '{0, 1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1};

    req_signed = '0; req_divd = '0; req_divs = '0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_div_o_ready", 64'(div_o_ready), 64'd0);
    chk("rst_quot", 64'(rsp_quot), 64'd0);
    chk("rst_divd", 64'(div_divd), 64'd0);

    foreach (tbl[i]) begin
      set_req(tbl[i].idx, tbl[i].s, tbl[i].a, tbl[i].b);
      run_op(tbl[i].idx, 1'b1, 0, got, w);
      chk("tbl_quot", 64'(got.q), 64'(tbl[i].q));
      chk("tbl_rem", 64'(got.r), 64'(tbl[i].r));
      chk("tbl_zdiv", 64'(got.z), 64'(tbl[i].z));
    end

    // Both requesting from reset: 0,1,0,1; requester 1 waits through a 10-cycle response stall.
    do_reset();
    set_req(0, 1'b0, 32'd100, 32'd7);
    set_req(1, 1'b1, 32'hFFFF_FFEC, 32'd3);
    run_op(0, 1'b0, 10, got, w);
    run_op(1, 1'b0, 0, got, w);
    chk("grant_after_stall_wait", 64'(w), 64'd0);
    run_op(0, 1'b1, 0, got, w);
    run_op(1, 1'b1, 0, got, w);

    // After requester 0 alone, the pointer favours 1.
    do_reset();
    set_req(0, 1'b0, 32'd50, 32'd5);
    run_op(0, 1'b1, 0, got, w);
    set_req(0, 1'b0, 32'd9, 32'd4);
    set_req(1, 1'b0, 32'd81, 32'd9);
    run_op(1, 1'b1, 0, got, w);
    run_op(0, 1'b1, 0, got, w);

    // Reset while waiting on the divider.
    do_reset();
    set_req(0, 1'b0, 32'd10, 32'd3);
    run_op(0, 1'b1, 0, got, w);
    set_req(1, 1'b0, 32'd1000, 32'd7);
    #1;
    n = 0;
    while (req_ready == 0 && n < 100) begin tick(); n++; end
    chk("rstw_grant", 64'(req_ready), 64'd2);
    tick();
    req_valid[1] = 1'b0;
    n = 0;
    while (div_valid && n < 100) begin tick(); n++; end
    chk("rstw_in_wait", 64'(div_o_ready), 64'd1);
    srst = 1;
    tick();
    srst = 0;
    mptr = 0;
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_div_valid", 64'(div_valid), 64'd0);
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstw_div_o_ready", 64'(div_o_ready), 64'd0);
    tick(); tick();
    chk("rstw_quiet", 64'(busy), 64'd0);
    set_req(0, 1'b1, 32'hFFFF_FF00, 32'd16);
    set_req(2, 1'b0, 32'd77, 32'd0);
    run_op(0, 1'b1, 0, got, w);
    run_op(2, 1'b1, 0, got, w);

    // Random traffic against the rotating-priority model.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NB; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 9) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 20)));
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (req_valid == 0) set_req($urandom_range(0, NB - 1), 1'b1, $urandom, 32'($urandom_range(1, 9)));
      e = predict(req_valid, mptr);
      run_op(e, 1'b1, $urandom_range(0, 3), got, w);
      chk("rand_no_wait", 64'(w), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
